// File: rtl/cr_sa_snap_reader.sv
// Snap/clear broadcaster and tear-free two-beat reader for a bank of 50-bit event counters.
// Control ops pulse the counters; READ captures one snapshot and serves it as lo/hi beats.
module cr_sa_snap_reader #(
    parameter int unsigned N_CNTR = 8,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_W-1:0]      cmd_idx,
    output logic                  sa_snap,
    output logic                  sa_clear,
    input  logic [50*N_CNTR-1:0]  sa_snapshot_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err
);

    localparam logic [1:0] OpSnap  = 2'd0;
    localparam logic [1:0] OpClear = 2'd1;
    localparam logic [1:0] OpRead  = 2'd3;

    typedef enum logic [2:0] {StIdle, StPulse, StSettle, StRdLo, StRdHi} state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        sa_snap_q, sa_snap_d;
    logic        sa_clear_q, sa_clear_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [13:0] snap_seq_q, snap_seq_d;
    logic [13:0] hold_seq_q, hold_seq_d;
    // Low half of the captured value lives in rsp_data_q until the low beat is consumed.
    logic [17:0] hold_hi_q, hold_hi_d;

    logic [49:0] sel;
    logic        idx_ok;
    logic [49:0] capture;

    always_comb begin
        sel    = '0;
        idx_ok = 1'b0;
        for (int unsigned i = 0; i < N_CNTR; i++) begin
            if (cmd_idx == IDX_W'(i)) begin
                sel    = sa_snapshot_in[50*i +: 50];
                idx_ok = 1'b1;
            end
        end
        capture = idx_ok ? sel : '0;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        sa_snap_d   = 1'b0;
        sa_clear_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        snap_seq_d  = snap_seq_q;
        hold_seq_d  = hold_seq_q;
        hold_hi_d   = hold_hi_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_op == OpRead) begin
                        state_d     = StRdLo;
                        hold_hi_d   = capture[49:32];
                        hold_seq_d  = snap_seq_q;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = capture[31:0];
                        rsp_last_d  = 1'b0;
                        rsp_err_d   = !idx_ok;
                    end else begin
                        state_d    = StPulse;
                        sa_snap_d  = (cmd_op != OpClear);
                        sa_clear_d = (cmd_op != OpSnap);
                        if (cmd_op != OpClear) begin
                            snap_seq_d = snap_seq_q + 14'd1;
                        end
                    end
                end
            end
            StPulse: begin
                state_d = StSettle;
            end
            StSettle: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
            end
            StRdLo: begin
                if (rsp_ready) begin
                    state_d    = StRdHi;
                    rsp_data_d = {hold_seq_q, hold_hi_q};
                    rsp_last_d = 1'b1;
                end
            end
            StRdHi: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            sa_snap_q   <= 1'b0;
            sa_clear_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            snap_seq_q  <= '0;
            hold_seq_q  <= '0;
            hold_hi_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            sa_snap_q   <= sa_snap_d;
            sa_clear_q  <= sa_clear_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            snap_seq_q  <= snap_seq_d;
            hold_seq_q  <= hold_seq_d;
            hold_hi_q   <= hold_hi_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign sa_snap   = sa_snap_q;
    assign sa_clear  = sa_clear_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
